// File: rtl/jpeg_rle_ctrl.sv
`default_nettype none
// ---- jpeg_rle_ctrl: zigzag coefficients -> (run, size, amplitude) symbols with ZRL/EOB ---
// ---- rev 1.0 -------------------------------------------------------------------------------
module jpeg_rle_ctrl #(
  parameter int AMP_W = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic [AMP_W-1:0] coef_in,
  input  logic             coef_valid,
  output logic             coef_ready,
  output logic [3:0]       sym_run,
  output logic [3:0]       sym_size,
  output logic [AMP_W-1:0] sym_amp,
  output logic             sym_eob,
  output logic             sym_valid,
  input  logic             sym_ready
);

  localparam logic [AMP_W-1:0] C_MIN_NEG = {1'b1, {(AMP_W-1){1'b0}}};
  localparam logic [AMP_W-1:0] C_MAX_POS = {1'b0, {(AMP_W-1){1'b1}}};

  typedef enum logic [1:0] {S_DC, S_AC, S_ZRL, S_EOB} state_t;

  state_t           state, state_n;
  logic [5:0]       idx, idx_n, zcnt, zcnt_n, lat_idx, lat_idx_n;
  logic [AMP_W-1:0] lat_coef, lat_coef_n;
  logic             emit, e_eob;
  logic [3:0]       e_run, e_size, in_size, lat_size;
  logic [AMP_W-1:0] e_amp, in_amp, lat_amp;
  logic             slot_free, in_fire, in_zero;

  // The most negative code is folded onto -(2^(AMP_W-1)-1) so its magnitude fits.
  function automatic logic [3:0] size_of(input logic [AMP_W-1:0] x);
    logic [AMP_W-1:0] m;
    logic [3:0]       s;
    m = x[AMP_W-1] ? ((x == C_MIN_NEG) ? C_MAX_POS : -x) : x;
    s = '0;
    for (int i = 0; i < AMP_W; i++)
      if (m[i]) s = 4'(i + 1);
    return s;
  endfunction

  function automatic logic [AMP_W-1:0] amp_of(input logic [AMP_W-1:0] x, input logic [3:0] s);
    logic [AMP_W-1:0] v;
    v = x[AMP_W-1] ? (((x == C_MIN_NEG) ? C_MIN_NEG + 1'b1 : x) - 1'b1) : x;
    return v & ~({AMP_W{1'b1}} << s);
  endfunction

  assign in_size  = size_of(coef_in);
  assign in_amp   = amp_of(coef_in, in_size);
  assign lat_size = size_of(lat_coef);
  assign lat_amp  = amp_of(lat_coef, lat_size);

  assign slot_free  = !sym_valid || sym_ready;
  assign coef_ready = ((state == S_DC) || (state == S_AC)) && slot_free;
  assign in_fire    = ena && coef_valid && coef_ready;
  assign in_zero    = (coef_in == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)     state <= S_DC;
    else if (ena) state <= state_n;
  end

  always_comb begin
    state_n    = state;
    idx_n      = idx;
    zcnt_n     = zcnt;
    lat_idx_n  = lat_idx;
    lat_coef_n = lat_coef;
    emit       = 1'b0;
    e_run      = '0;
    e_size     = '0;
    e_amp      = '0;
    e_eob      = 1'b0;
    case (state)
      S_DC: if (in_fire) begin
        emit    = 1'b1;
        e_size  = in_size;
        e_amp   = in_amp;
        idx_n   = 6'd1;
        state_n = S_AC;
      end
      S_AC: if (in_fire) begin
        if (in_zero) begin
          if (idx == 6'd63) state_n = S_EOB;
          else begin
            zcnt_n = zcnt + 6'd1;
            idx_n  = idx + 6'd1;
          end
        end else if (zcnt < 6'd16) begin
          emit    = 1'b1;
          e_run   = zcnt[3:0];
          e_size  = in_size;
          e_amp   = in_amp;
          zcnt_n  = '0;
          idx_n   = idx + 6'd1;
          state_n = (idx == 6'd63) ? S_DC : S_AC;
        end else begin
          lat_coef_n = coef_in;
          lat_idx_n  = idx;
          state_n    = S_ZRL;
        end
      end
      S_ZRL: if (ena && slot_free) begin
        emit = 1'b1;
        if (zcnt >= 6'd16) begin
          e_run  = 4'd15;
          zcnt_n = zcnt - 6'd16;
        end else begin
          e_run   = zcnt[3:0];
          e_size  = lat_size;
          e_amp   = lat_amp;
          zcnt_n  = '0;
          idx_n   = lat_idx + 6'd1;
          state_n = (lat_idx == 6'd63) ? S_DC : S_AC;
        end
      end
      S_EOB: if (ena && slot_free) begin
        emit    = 1'b1;
        e_eob   = 1'b1;
        zcnt_n  = '0;
        idx_n   = '0;
        state_n = S_DC;
      end
      default: state_n = S_DC;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx       <= '0;
      zcnt      <= '0;
      lat_idx   <= '0;
      lat_coef  <= '0;
      sym_valid <= 1'b0;
      sym_run   <= '0;
      sym_size  <= '0;
      sym_amp   <= '0;
      sym_eob   <= 1'b0;
    end else if (ena) begin
      idx      <= idx_n;
      zcnt     <= zcnt_n;
      lat_idx  <= lat_idx_n;
      lat_coef <= lat_coef_n;
      if (emit) begin
        sym_valid <= 1'b1;
        sym_run   <= e_run;
        sym_size  <= e_size;
        sym_amp   <= e_amp;
        sym_eob   <= e_eob;
      end else if (sym_ready) begin
        sym_valid <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_jpeg_rle_ctrl.sv
`default_nettype none
// ---- tb_jpeg_rle_ctrl: directed self-checking bench for jpeg_rle_ctrl ----------------------
// ---- rev 1.0 -------------------------------------------------------------------------------
module tb_jpeg_rle_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ena = 1'b1;
  logic [11:0] coef_in = '0;
  logic        coef_valid = 1'b0;
  logic        coef_ready;
  logic [3:0]  sym_run, sym_size;
  logic [11:0] sym_amp;
  logic        sym_eob, sym_valid;
  logic        sym_ready = 1'b1;

  typedef struct packed {
    logic [3:0]  run;
    logic [3:0]  size;
    logic [11:0] amp;
    logic        eob;
  } sym_t;

  sym_t got[$];
  sym_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   zrl_stall = 0;

  jpeg_rle_ctrl #(.AMP_W(12)) dut (
    .clk(clk), .rst(rst), .ena(ena),
    .coef_in(coef_in), .coef_valid(coef_valid), .coef_ready(coef_ready),
    .sym_run(sym_run), .sym_size(sym_size), .sym_amp(sym_amp),
    .sym_eob(sym_eob), .sym_valid(sym_valid), .sym_ready(sym_ready)
  );

  always #5 clk = ~clk;

  // Symbols are recorded on the falling edge preceding the rising edge that accepts them.
  always @(negedge clk) begin
    if (rst && ena && sym_valid && sym_ready)
      got.push_back({sym_run, sym_size, sym_amp, sym_eob});
    if (rst && ena && sym_valid && sym_run == 4'd15 && sym_size == 4'd0 && !sym_eob && !coef_ready)
      zrl_stall++;
  end

  function automatic sym_t mk(input int r, input int s, input int a, input bit e);
    sym_t t;
    t.run  = 4'(r);
    t.size = 4'(s);
    t.amp  = 12'(a);
    t.eob  = e;
    return t;
  endfunction

  task automatic send(input int v);
    int waited = 0;
    bit done = 1'b0;
    coef_in    = 12'(v);
    coef_valid = 1'b1;
    while (!done) begin
      @(negedge clk);
      if (coef_ready && ena) done = 1'b1;
      else begin
        waited++;
        if (waited > 50) begin
          n_cmp++;
          n_bad++;
          $display("FAIL send_timeout: coef_ready=%0b after %0d cycles, required 1", coef_ready, waited);
          done = 1'b1;
        end
      end
    end
    @(posedge clk);
    #1;
    coef_valid = 1'b0;
  endtask

  task automatic settle();
    repeat (8) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #12;
    n_cmp++;
    if ({sym_valid, sym_run, sym_size, sym_amp, sym_eob} !== 22'd0) begin
      n_bad++;
      $display("FAIL reset_outputs: got valid=%0b run=%0d size=%0d amp=%0h eob=%0b, required all 0",
               sym_valid, sym_run, sym_size, sym_amp, sym_eob);
    end
    n_cmp++;
    if (coef_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_coef_ready: got %0b, required 1", coef_ready);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (sym_valid !== 1'b0 || coef_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_release: got valid=%0b coef_ready=%0b, required 0/1", sym_valid, coef_ready);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    got.delete();
    exp_q.delete();
    exp_q.push_back(mk(0, 3, 5, 0));
    exp_q.push_back(mk(0, 2, 0, 0));
    exp_q.push_back(mk(0, 0, 0, 1));
    for (int i = 0; i < 64; i++) send(i == 0 ? 5 : (i == 1 ? -3 : 0));
    settle();
    n_cmp++;
    if (got.size() != exp_q.size()) begin
      n_bad++;
      $display("FAIL basic_count: got %0d symbols, required %0d", got.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < got.size()) begin
      n_cmp++;
      if (got[i] !== exp_q[i]) begin
        n_bad++;
        $display("FAIL basic_sym[%0d]: got %0d/%0d/%0h/%0b, required %0d/%0d/%0h/%0b", i,
                 got[i].run, got[i].size, got[i].amp, got[i].eob,
                 exp_q[i].run, exp_q[i].size, exp_q[i].amp, exp_q[i].eob);
      end
    end
  endtask

  task automatic test_zrl();
    got.delete();
    exp_q.delete();
    exp_q.push_back(mk(0, 0, 0, 0));
    exp_q.push_back(mk(15, 0, 0, 0));
    exp_q.push_back(mk(4, 1, 1, 0));
    exp_q.push_back(mk(0, 0, 0, 1));
    for (int i = 0; i < 64; i++) send(i == 21 ? 1 : 0);
    settle();
    n_cmp++;
    if (got.size() != exp_q.size()) begin
      n_bad++;
      $display("FAIL zrl_count: got %0d symbols, required %0d", got.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < got.size()) begin
      n_cmp++;
      if (got[i] !== exp_q[i]) begin
        n_bad++;
        $display("FAIL zrl_sym[%0d]: got %0d/%0d/%0h/%0b, required %0d/%0d/%0h/%0b", i,
                 got[i].run, got[i].size, got[i].amp, got[i].eob,
                 exp_q[i].run, exp_q[i].size, exp_q[i].amp, exp_q[i].eob);
      end
    end
  endtask

  task automatic test_all_ones();
    got.delete();
    exp_q.delete();
    for (int i = 0; i < 64; i++) exp_q.push_back(mk(0, 1, 1, 0));
    exp_q.push_back(mk(0, 0, 0, 0));
    exp_q.push_back(mk(0, 0, 0, 1));
    for (int i = 0; i < 64; i++) send(1);
    for (int i = 0; i < 64; i++) send(0);
    settle();
    n_cmp++;
    if (got.size() != exp_q.size()) begin
      n_bad++;
      $display("FAIL ones_count: got %0d symbols, required %0d", got.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < got.size()) begin
      n_cmp++;
      if (got[i] !== exp_q[i]) begin
        n_bad++;
        $display("FAIL ones_sym[%0d]: got %0d/%0d/%0h/%0b, required %0d/%0d/%0h/%0b", i,
                 got[i].run, got[i].size, got[i].amp, got[i].eob,
                 exp_q[i].run, exp_q[i].size, exp_q[i].amp, exp_q[i].eob);
      end
    end
  endtask

  task automatic test_last_nonzero();
    got.delete();
    exp_q.delete();
    zrl_stall = 0;
    exp_q.push_back(mk(0, 3, 7, 0));
    repeat (3) exp_q.push_back(mk(15, 0, 0, 0));
    exp_q.push_back(mk(14, 1, 0, 0));
    exp_q.push_back(mk(0, 0, 0, 0));
    exp_q.push_back(mk(0, 0, 0, 1));
    for (int i = 0; i < 64; i++) send(i == 0 ? 7 : (i == 63 ? -1 : 0));
    for (int i = 0; i < 64; i++) send(0);
    settle();
    n_cmp++;
    if (zrl_stall != 3) begin
      n_bad++;
      $display("FAIL last_zrl_stall: coef_ready low during %0d ZRL cycles, required 3", zrl_stall);
    end
    n_cmp++;
    if (got.size() != exp_q.size()) begin
      n_bad++;
      $display("FAIL last_count: got %0d symbols, required %0d", got.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < got.size()) begin
      n_cmp++;
      if (got[i] !== exp_q[i]) begin
        n_bad++;
        $display("FAIL last_sym[%0d]: got %0d/%0d/%0h/%0b, required %0d/%0d/%0h/%0b", i,
                 got[i].run, got[i].size, got[i].amp, got[i].eob,
                 exp_q[i].run, exp_q[i].size, exp_q[i].amp, exp_q[i].eob);
      end
    end
  endtask

  task automatic test_sizes();
    got.delete();
    exp_q.delete();
    exp_q.push_back(mk(0, 11, 12'h000, 0));
    exp_q.push_back(mk(0, 11, 12'h7FF, 0));
    exp_q.push_back(mk(0, 11, 12'h3FF, 0));
    exp_q.push_back(mk(0, 7, 100, 0));
    exp_q.push_back(mk(0, 0, 0, 1));
    for (int i = 0; i < 64; i++)
      send(i == 0 ? -2048 : (i == 1 ? 2047 : (i == 2 ? -1024 : (i == 3 ? 100 : 0))));
    settle();
    n_cmp++;
    if (got.size() != exp_q.size()) begin
      n_bad++;
      $display("FAIL sizes_count: got %0d symbols, required %0d", got.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < got.size()) begin
      n_cmp++;
      if (got[i] !== exp_q[i]) begin
        n_bad++;
        $display("FAIL sizes_sym[%0d]: got %0d/%0d/%0h/%0b, required %0d/%0d/%0h/%0b", i,
                 got[i].run, got[i].size, got[i].amp, got[i].eob,
                 exp_q[i].run, exp_q[i].size, exp_q[i].amp, exp_q[i].eob);
      end
    end
  endtask

  task automatic test_backpressure();
    got.delete();
    exp_q.delete();
    exp_q.push_back(mk(0, 1, 1, 0));
    exp_q.push_back(mk(0, 2, 2, 0));
    exp_q.push_back(mk(0, 2, 3, 0));
    exp_q.push_back(mk(0, 3, 4, 0));
    exp_q.push_back(mk(0, 0, 0, 1));
    send(1);
    send(2);
    send(3);
    sym_ready  = 1'b0;
    coef_in    = 12'd4;
    coef_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_cmp++;
      if (coef_ready !== 1'b0 || sym_valid !== 1'b1 ||
          {sym_run, sym_size, sym_amp, sym_eob} !== {4'd0, 4'd2, 12'd3, 1'b0}) begin
        n_bad++;
        $display("FAIL stall_hold[%0d]: got ready=%0b valid=%0b sym=%0d/%0d/%0h/%0b, required 0/1 0/2/3/0",
                 c, coef_ready, sym_valid, sym_run, sym_size, sym_amp, sym_eob);
      end
      @(posedge clk);
      #1;
    end
    sym_ready = 1'b1;
    ena       = 1'b0;
    repeat (2) begin
      @(negedge clk);
      n_cmp++;
      if (sym_valid !== 1'b1 || {sym_run, sym_size, sym_amp} !== {4'd0, 4'd2, 12'd3}) begin
        n_bad++;
        $display("FAIL ena_hold: got valid=%0b sym=%0d/%0d/%0h, required 1 0/2/3",
                 sym_valid, sym_run, sym_size, sym_amp);
      end
      @(posedge clk);
      #1;
    end
    ena = 1'b1;
    send(4);
    for (int i = 4; i < 64; i++) send(0);
    settle();
    n_cmp++;
    if (got.size() != exp_q.size()) begin
      n_bad++;
      $display("FAIL stall_count: got %0d symbols, required %0d", got.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < got.size()) begin
      n_cmp++;
      if (got[i] !== exp_q[i]) begin
        n_bad++;
        $display("FAIL stall_sym[%0d]: got %0d/%0d/%0h/%0b, required %0d/%0d/%0h/%0b", i,
                 got[i].run, got[i].size, got[i].amp, got[i].eob,
                 exp_q[i].run, exp_q[i].size, exp_q[i].amp, exp_q[i].eob);
      end
    end
  endtask

  task automatic test_reset_in_zrl();
    got.delete();
    exp_q.delete();
    exp_q.push_back(mk(0, 1, 1, 0));
    exp_q.push_back(mk(0, 0, 0, 0));
    exp_q.push_back(mk(0, 0, 0, 1));
    for (int i = 0; i < 42; i++) send(i == 0 ? 1 : (i == 41 ? 5 : 0));
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_cmp++;
    if (sym_valid !== 1'b0 || coef_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL zrl_reset_async: got valid=%0b coef_ready=%0b, required 0/1", sym_valid, coef_ready);
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if (sym_valid !== 1'b0 || {sym_run, sym_size, sym_amp, sym_eob} !== 21'd0) begin
      n_bad++;
      $display("FAIL zrl_reset_hold: got valid=%0b sym=%0d/%0d/%0h/%0b, required 0 0/0/0/0",
               sym_valid, sym_run, sym_size, sym_amp, sym_eob);
    end
    rst = 1'b1;
    for (int i = 0; i < 64; i++) send(0);
    settle();
    n_cmp++;
    if (got.size() != exp_q.size()) begin
      n_bad++;
      $display("FAIL zrlrst_count: got %0d symbols, required %0d", got.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < got.size()) begin
      n_cmp++;
      if (got[i] !== exp_q[i]) begin
        n_bad++;
        $display("FAIL zrlrst_sym[%0d]: got %0d/%0d/%0h/%0b, required %0d/%0d/%0h/%0b", i,
                 got[i].run, got[i].size, got[i].amp, got[i].eob,
                 exp_q[i].run, exp_q[i].size, exp_q[i].amp, exp_q[i].eob);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zrl();
    test_all_ones();
    test_last_nonzero();
    test_sizes();
    test_backpressure();
    test_reset_in_zrl();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/jpeg_rle_ctrl.md
JPEG_RLE_CTRL -- requirements
Module: jpeg_rle_ctrl

Interface
REQ-001 The block SHALL have parameter AMP_W, default 12, giving the coefficient and amplitude width in bits.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port ena, input, 1 bit: clock enable; when low, no transfer occurs and all state holds.
REQ-005 The block SHALL have port coef_in, input, AMP_W bits: signed two's-complement coefficient in zigzag order.
REQ-006 The block SHALL have port coef_valid, input, 1 bit: coef_in is valid.
REQ-007 The block SHALL have port coef_ready, output, 1 bit: the block can accept a coefficient.
REQ-008 The block SHALL have port sym_run, output, 4 bits: zero-run length.
REQ-009 The block SHALL have port sym_size, output, 4 bits: magnitude category.
REQ-010 The block SHALL have port sym_amp, output, AMP_W bits: amplitude bits.
REQ-011 The block SHALL have port sym_eob, output, 1 bit: high when the current symbol is an EOB.
REQ-012 The block SHALL have port sym_valid, output, 1 bit: a symbol is presented.
REQ-013 The block SHALL have port sym_ready, input, 1 bit: the downstream side accepts the symbol.

Function
REQ-014 A transfer SHALL occur on a rising clk edge only when valid, ready and ena are all high.
REQ-015 coef_ready SHALL equal (state is DC or AC) AND (sym_valid is low OR sym_ready is high).
REQ-016 The output register SHALL hold sym_* stable while sym_valid is high and sym_ready is low.
REQ-017 Each block SHALL consist of 64 coefficients; a 6-bit index counter SHALL give the position, with 0 being DC.
REQ-018 The state machine SHALL have the states DC, AC, ZRL and EOB.
REQ-019 In state DC, accepting a coefficient SHALL emit (run 0, size, amp) even when the coefficient is zero; the index SHALL become 1 and the state SHALL become AC.
REQ-020 In state AC, accepting a zero at an index below 63 SHALL increment the zero counter (zcnt, 6 bits) and SHALL emit nothing.
REQ-021 In state AC, accepting a zero at index 63 SHALL move the state to EOB.
REQ-022 In state EOB, the block SHALL emit (0, 0, 0) with sym_eob=1 when the output slot is free, then clear zcnt and return to DC.
REQ-023 In state AC, accepting a nonzero coefficient with zcnt<16 SHALL emit (zcnt, size, amp) and clear zcnt.
REQ-024 In state AC, accepting a nonzero coefficient with zcnt>=16 SHALL latch the coefficient and its index and move to state ZRL without emitting.
REQ-025 In state ZRL, for each free output slot, the block SHALL emit ZRL (15, 0, 0) and subtract 16 from zcnt while zcnt>=16.
REQ-026 In state ZRL, once zcnt<16, the block SHALL emit the latched coefficient as (zcnt, size, amp) and clear zcnt.
REQ-027 After the latched coefficient is emitted from state ZRL, the state SHALL become AC, or DC if the latched index was 63.
REQ-028 A nonzero coefficient at index 63 SHALL end the block with no EOB.
REQ-029 Trailing zeros SHALL never produce ZRL symbols.
REQ-030 sym_size SHALL be the bit length of |x|: 0 for 0, 1 for ±1, 2 for ±2..3, up to 11 for ±1024..2047.
REQ-031 An input of -2^(AMP_W-1) SHALL be treated as -(2^(AMP_W-1)-1).
REQ-032 sym_amp SHALL be x for x>=0 and x-1 for x<0, masked to the low sym_size bits, with all upper bits 0.
REQ-033 sym_eob SHALL be 0 for every non-EOB symbol.
REQ-034 Throughput SHALL be one coefficient per cycle when sym_ready is held high, except for stall cycles in states ZRL and EOB.
REQ-035 Symbol latency SHALL be 1 cycle from the coefficient transfer to sym_valid.

Reset
REQ-036 On rst low, the state SHALL become DC; index, zcnt, the latched coefficient, sym_valid, sym_run, sym_size, sym_amp and sym_eob SHALL all become 0, asynchronously.
REQ-037 A reset in mid-block, including in state ZRL or EOB, SHALL discard the partial block; the first coefficient after reset release SHALL be treated as DC.

Verification
REQ-038 The bench SHALL cover: DC=5, AC1=-3, AC2..63=0 -> (0,3,5), (0,2,0), EOB (0,0,0, eob=1).
REQ-039 The bench SHALL cover: DC=0, AC1..20=0, AC21=1, rest 0 -> (0,0,0), ZRL (15,0,0), (4,1,1), EOB.
REQ-040 The bench SHALL cover: all 64 coefficients = 1 -> 64 symbols (0,1,1), no EOB, next coefficient taken as DC.
REQ-041 The bench SHALL cover: DC=7, AC1..62=0, AC63=-1 -> (0,3,7), 3× ZRL, (14,1,0), no EOB, coef_ready low for 3 cycles.
REQ-042 The bench SHALL cover: sym_ready held low for 5 cycles mid-block -> coef_ready low and sym_* stable throughout; no symbol lost or duplicated.
REQ-043 The bench SHALL cover: rst asserted in state ZRL with zcnt=40 -> sym_valid=0 immediately; after release, the next coefficient produces a run-0 DC symbol.
